decoder38_led_driver: RTL and testbench
=======================================

// Module: decoder38_led_driver
// PURPOSE
//  Inverse of the 8->3 priority-encoder front end: latches a 3-bit code and drives one
//  of 8 board LEDs (one-hot), with static, blink and sweep (walk up/down) display modes.
//  Sits between control logic or switches and the LED bank.
//  All outputs are registered; one-cycle latency from sampled inputs to led.
// PARAMETERS
//  TICK_DIV   5_000_000  clk cycles per display tick; legal range >=2.
//  CNT_W      $clog2(TICK_DIV)  width of the prescaler counter (derived, do not override).
// PORTS
//  clk     in   1  system clock, rising edge
//  rst     in   1  asynchronous, active-high reset
//  en      in   1  display enable; 0 blanks led, freezes tick counter
//  load    in   1  1-cycle strobe: capture code, enter RUN
//  clr     in   1  1-cycle strobe: drop code, return to IDLE
//  code    in   3  LED index 0..7 to light
//  mode    in   2  00 static, 01 blink, 10 sweep-up, 11 sweep-down
//  led     out  8  one-hot LED drive (or 8'h00)
//  pos     out  3  current latched index
//  flag    out  1  1 when a code is held and en=1 (RUN & en)
// BEHAVIOUR
//  Reset (async, any time): state=IDLE, pos=0, led=8'h00, flag=0, counter=0, phase=1.
//  FSM: IDLE --load--> RUN; RUN --clr--> IDLE; RUN --load--> RUN (reload).
//   clr and load in same cycle: clr wins -> IDLE, code ignored.
//  load (not clr): pos<=code, counter<=0, phase<=1, state<=RUN; led shows new index next cycle.
//  Prescaler: counts 0..TICK_DIV-1 only when state==RUN && en; tick pulses 1 cycle when
//   count==TICK_DIV-1, counter wraps to 0. In IDLE or en=0 counter holds its value.
//  load and tick same cycle: load wins (no pos step, no phase toggle, counter cleared).
//  Mode actions on tick: 01 phase<=~phase; 10 pos<=pos+1 (7->0 wrap);
//   11 pos<=pos-1 (0->7 wrap); 00 no effect. phase forced to 1 whenever mode!=01.
//  mode change: sampled every cycle, effective on next tick; no counter reset.
//  led (registered): IDLE or en=0 -> 8'h00; RUN,en=1 -> (phase ? 8'b1<<pos_next : 8'h00),
//   where pos_next is the value pos takes this edge (led and pos always consistent).
//  flag (registered) <= (next state==RUN) && en.
//  code is sampled only on load; changes at other times are ignored.
//  Reset asserted mid-tick or mid-blink: all state cleared immediately; on release, IDLE.
// STRUCTURE
//  Package decoder38_pkg: localparams MODE_STATIC=2'b00, MODE_BLINK=2'b01,
//   MODE_SWEEP_UP=2'b10, MODE_SWEEP_DN=2'b11; state encoding ST_IDLE=1'b0, ST_RUN=1'b1.
//  Sub-module tick_gen (TICK_DIV param; inputs clk,rst,run,clr_cnt; output tick):
//   owns the prescaler; top holds FSM, pos, phase, output registers.
// TESTING (bench uses TICK_DIV=4)
//  1 rst pulse mid-run -> led=00,pos=0,flag=0 same cycle as rst; stays IDLE after release.
//  2 en=1,mode=00,load code=5 -> next cycle led=8'h20,pos=5,flag=1; stable over 20 cycles.
//  3 mode=01,load code=2 -> led 04 for 4 cycles, 00 for 4, 04 for 4 (period 8).
//  4 mode=10,load code=6 -> pos 6,7,0,1 every 4 cycles; led 40,80,01,02; mode=11 from 7 -> 7,6.
//  5 load and clr same cycle in RUN -> IDLE, led=00, flag=0; load on tick cycle -> no step.
//  6 en=0 for 10 cycles in sweep -> led=00, flag=0, pos frozen; en=1 -> resumes same count.

Source files
------------

// File: rtl/decoder38_pkg.sv
// Shared mode codes, FSM state encoding and one-hot helper for the 3->8 LED driver.
// Pure declarations: no logic, no latency, no flow control.
package decoder38_pkg;

  localparam logic [1:0] MODE_STATIC   = 2'b00;
  localparam logic [1:0] MODE_BLINK    = 2'b01;
  localparam logic [1:0] MODE_SWEEP_UP = 2'b10;
  localparam logic [1:0] MODE_SWEEP_DN = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'(1) << idx;
  endfunction

endpackage

// File: rtl/decoder38_led_driver_if.sv
// Control/display bundle between the controlling logic (master) and the LED driver (slave).
// Level signals plus single-cycle load/clr strobes; no handshake, the driver never stalls.
interface decoder38_led_driver_if;
  logic       en;
  logic       load;
  logic       clr;
  logic [2:0] code;
  logic [1:0] mode;
  logic [7:0] led;
  logic [2:0] pos;
  logic       flag;

  modport master (
    output en, load, clr, code, mode,
    input  led, pos, flag
  );

  modport slave (
    input  en, load, clr, code, mode,
    output led, pos, flag
  );
endinterface

// File: rtl/tick_gen.sv
// Display-tick prescaler: counts 0..TICK_DIV-1 while run, tick is combinational on the last count.
// clr_cnt restarts the count and overrides run; with run low the count holds its value.
module tick_gen #(
  parameter int TICK_DIV = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr_cnt,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = run && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr_cnt) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/decoder38_led_driver.sv
// Latches a 3-bit code and drives one of 8 LEDs one-hot with static, blink and sweep modes.
// All outputs registered, one cycle from sampled inputs; never applies backpressure.
module decoder38_led_driver
  import decoder38_pkg::*;
#(
  parameter int TICK_DIV = 5_000_000
) (
  input  logic                          clk,
  input  logic                          rst,
  decoder38_led_driver_if.slave         bus
);

  state_t     state_q, state_d;
  logic [2:0] pos_q, pos_d;
  logic       phase_q, phase_d;
  logic [7:0] led_q, led_d;
  logic       flag_q, flag_d;
  logic       run;
  logic       do_load;
  logic       tick;

  assign run     = (state_q == ST_RUN) && bus.en;
  assign do_load = bus.load && !bus.clr;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .clr_cnt (do_load),
    .tick    (tick)
  );

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    phase_d = phase_q;

    // clr beats load; load beats a coincident tick
    if (bus.clr) begin
      state_d = ST_IDLE;
      pos_d   = 3'd0;
    end else if (bus.load) begin
      state_d = ST_RUN;
      pos_d   = bus.code;
      phase_d = 1'b1;
    end else if (tick) begin
      unique case (bus.mode)
        MODE_BLINK:    phase_d = ~phase_q;
        MODE_SWEEP_UP: pos_d   = pos_q + 3'd1;
        MODE_SWEEP_DN: pos_d   = pos_q - 3'd1;
        default:       ;
      endcase
    end

    if (bus.mode != MODE_BLINK) begin
      phase_d = 1'b1;
    end

    flag_d = (state_d == ST_RUN) && bus.en;
    led_d  = (flag_d && phase_d) ? onehot8(pos_d) : 8'h00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pos_q   <= 3'd0;
      phase_q <= 1'b1;
      led_q   <= 8'h00;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      phase_q <= phase_d;
      led_q   <= led_d;
      flag_q  <= flag_d;
    end
  end

  assign bus.led  = led_q;
  assign bus.pos  = pos_q;
  assign bus.flag = flag_q;

endmodule

// File: tb/tb_decoder38_led_driver.sv
// Directed-vector bench for decoder38_led_driver with TICK_DIV=4 (one display tick per 4 clocks).
module tb_decoder38_led_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  decoder38_led_driver_if bus();

  decoder38_led_driver #(
    .TICK_DIV (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // advance one clock; outputs are sampled 1ns after the rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [2:0] c, input logic [1:0] m);
    bus.code = c;
    bus.mode = m;
    bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
  endtask

  logic [2:0] exp_pos;

  initial begin
    bus.en   = 1'b0;
    bus.load = 1'b0;
    bus.clr  = 1'b0;
    bus.code = 3'd0;
    bus.mode = 2'b00;

    // reset state
    repeat (3) cyc();
    chk("rst_led", 32'(bus.led), 32'h00);
    chk("rst_pos", 32'(bus.pos), 32'd0);
    chk("rst_flag", 32'(bus.flag), 32'd0);
    rst = 1'b0;
    bus.en = 1'b1;
    cyc();
    chk("idle_led", 32'(bus.led), 32'h00);
    chk("idle_flag", 32'(bus.flag), 32'd0);

    // static mode, code 5, stable over 20 cycles
    do_load(3'd5, 2'b00);
    chk("static_led", 32'(bus.led), 32'h20);
    chk("static_pos", 32'(bus.pos), 32'd5);
    chk("static_flag", 32'(bus.flag), 32'd1);
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("static_hold", 32'(bus.led), 32'h20);
    end

    // blink, code 2: 4 on, 4 off, 4 on
    do_load(3'd2, 2'b01);
    for (int i = 0; i < 12; i++) begin
      chk("blink_led", 32'(bus.led), ((i / 4) % 2 == 0) ? 32'h04 : 32'h00);
      chk("blink_pos", 32'(bus.pos), 32'd2);
      cyc();
    end

    // sweep up from 6: 6,7,0,1 each held 4 cycles
    do_load(3'd6, 2'b10);
    for (int i = 0; i < 16; i++) begin
      exp_pos = 3'(6 + i / 4);
      chk("sweep_up_pos", 32'(bus.pos), 32'(exp_pos));
      chk("sweep_up_led", 32'(bus.led), 32'h1 << exp_pos);
      cyc();
    end

    // sweep up from 6, switch to down once at 7 without restarting the count: 6,7,6,5
    do_load(3'd6, 2'b10);
    for (int i = 0; i < 16; i++) begin
      if (i == 5) bus.mode = 2'b11;
      case (i / 4)
        0:       exp_pos = 3'd6;
        1:       exp_pos = 3'd7;
        2:       exp_pos = 3'd6;
        default: exp_pos = 3'd5;
      endcase
      chk("sweep_dn_pos", 32'(bus.pos), 32'(exp_pos));
      chk("sweep_dn_led", 32'(bus.led), 32'h1 << exp_pos);
      cyc();
    end

    // sweep down wraps 0 -> 7
    do_load(3'd0, 2'b11);
    repeat (4) cyc();
    chk("dn_wrap_pos", 32'(bus.pos), 32'd7);
    chk("dn_wrap_led", 32'(bus.led), 32'h80);

    // load and clr together: clr wins
    bus.code  = 3'd3;
    bus.load  = 1'b1;
    bus.clr   = 1'b1;
    cyc();
    bus.load  = 1'b0;
    bus.clr   = 1'b0;
    chk("ldclr_led", 32'(bus.led), 32'h00);
    chk("ldclr_flag", 32'(bus.flag), 32'd0);
    repeat (5) cyc();
    chk("ldclr_idle_led", 32'(bus.led), 32'h00);
    chk("ldclr_idle_flag", 32'(bus.flag), 32'd0);

    // load on the tick cycle: no step, count restarts
    do_load(3'd4, 2'b10);
    repeat (3) cyc();
    chk("pre_tick_pos", 32'(bus.pos), 32'd4);
    do_load(3'd4, 2'b10);
    chk("ldtick_pos", 32'(bus.pos), 32'd4);
    chk("ldtick_led", 32'(bus.led), 32'h10);
    repeat (3) cyc();
    chk("ldtick_hold_pos", 32'(bus.pos), 32'd4);
    cyc();
    chk("ldtick_step_pos", 32'(bus.pos), 32'd5);
    chk("ldtick_step_led", 32'(bus.led), 32'h20);

    // code changes outside load are ignored
    bus.code = 3'd1;
    cyc();
    chk("code_ignored", 32'(bus.pos), 32'd5);

    // en low in sweep: blanked and frozen, then resumes mid-count
    do_load(3'd0, 2'b10);
    repeat (2) cyc();
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("en0_led", 32'(bus.led), 32'h00);
      chk("en0_flag", 32'(bus.flag), 32'd0);
      chk("en0_pos", 32'(bus.pos), 32'd0);
    end
    bus.en = 1'b1;
    cyc();
    chk("en1_pos", 32'(bus.pos), 32'd0);
    chk("en1_led", 32'(bus.led), 32'h01);
    chk("en1_flag", 32'(bus.flag), 32'd1);
    cyc();
    chk("en1_step_pos", 32'(bus.pos), 32'd1);
    chk("en1_step_led", 32'(bus.led), 32'h02);

    // async reset mid-cycle while running in blink
    do_load(3'd3, 2'b01);
    cyc();
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_led", 32'(bus.led), 32'h00);
    chk("async_rst_pos", 32'(bus.pos), 32'd0);
    chk("async_rst_flag", 32'(bus.flag), 32'd0);
    cyc();
    rst = 1'b0;
    repeat (6) cyc();
    chk("post_rst_led", 32'(bus.led), 32'h00);
    chk("post_rst_flag", 32'(bus.flag), 32'd0);
    chk("post_rst_pos", 32'(bus.pos), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
